// File: rtl/signal_conflict_monitor.sv
// Safety monitor for the 12-bit lamp bus: latches the first unsafe indication as a fault code and requests flashing red.
// Latency: lamps registered, violation latched one edge later (2 cycles). Never backpressures; fault_cnt is live only with CONFLICT_MON_COUNT_EN.
module signal_conflict_monitor #(
    parameter int MIN_YELLOW     = 4,
    parameter int INVALID_CYCLES = 3,
    parameter int FLASH_DIV      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] lamps,
    input  logic        fault_clr,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic        flash_red,
    output logic [7:0]  fault_cnt
);

    localparam logic [1:0] ST_UNK = 2'd0;
    localparam logic [1:0] ST_RED = 2'd1;
    localparam logic [1:0] ST_GRN = 2'd2;
    localparam logic [1:0] ST_YEL = 2'd3;

    localparam int TW = $clog2(MIN_YELLOW + 1);
    localparam int RW = $clog2(INVALID_CYCLES + 1);
    localparam int FW = $clog2(FLASH_DIV);

    localparam logic [TW-1:0] Y_ONE    = 1;
    localparam logic [TW-1:0] Y_MIN    = TW'(MIN_YELLOW);
    localparam logic [RW-1:0] R_ONE    = 1;
    localparam logic [RW-1:0] RUN_MAX  = RW'(INVALID_CYCLES);
    localparam logic [RW-1:0] RUN_LIM  = RW'(INVALID_CYCLES - 1);
    localparam logic [FW-1:0] F_ONE    = 1;
    localparam logic [FW-1:0] FDIV_END = FW'(FLASH_DIV - 1);

    logic [11:0]         lamps_q;
    logic [2:0][1:0]     st_q;
    logic [2:0][TW-1:0]  ytmr_q;
    logic [3:0][RW-1:0]  run_q;
    logic [FW-1:0]       fdiv_q;

    logic [2:0] is_red, is_yel, is_grn, valid, moving;
    logic [3:0] bad;
    logic       v1, v2, v3, v4, v5, v6, v7;
    logic [2:0] viol_code;
    logic       clear_ok;

    always_comb begin
        is_red = '0;
        is_yel = '0;
        is_grn = '0;
        for (int a = 0; a < 3; a++) begin
            case (lamps_q[11-3*a -: 3])
                3'b100:  is_red[a] = 1'b1;
                3'b010:  is_yel[a] = 1'b1;
                3'b001:  is_grn[a] = 1'b1;
                default: ;
            endcase
        end
        valid  = is_red | is_yel | is_grn;
        moving = is_yel | is_grn;
        // Source 3 is the pedestrian pair: orange and white lit together is not a legal indication.
        bad    = {lamps_q[1] & lamps_q[0], ~valid};

        v1 = (moving[0] & moving[1]) | (moving[0] & moving[2]) | (moving[1] & moving[2]);
        v2 = lamps_q[0] & (|moving);
        v3 = 1'b0;
        v4 = 1'b0;
        v5 = 1'b0;
        for (int a = 0; a < 3; a++) begin
            if (st_q[a] == ST_GRN && is_red[a])                      v3 = 1'b1;
            if (st_q[a] == ST_YEL && is_red[a] && ytmr_q[a] < Y_MIN) v4 = 1'b1;
            if (st_q[a] == ST_YEL && is_grn[a])                      v5 = 1'b1;
        end
        v6 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bad[i] && run_q[i] >= RUN_LIM) v6 = 1'b1;
        end
        v7 = lamps_q[2] & ~is_grn[0];

        if      (v1) viol_code = 3'd1;
        else if (v2) viol_code = 3'd2;
        else if (v3) viol_code = 3'd3;
        else if (v4) viol_code = 3'd4;
        else if (v5) viol_code = 3'd5;
        else if (v6) viol_code = 3'd6;
        else if (v7) viol_code = 3'd7;
        else         viol_code = 3'd0;

        clear_ok = fault & fault_clr & (viol_code == 3'd0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lamps_q    <= '0;
            st_q       <= '{default: ST_UNK};
            ytmr_q     <= '0;
            run_q      <= '0;
            fdiv_q     <= '0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            flash_red  <= 1'b0;
        end else begin
            lamps_q <= lamps;

            for (int a = 0; a < 3; a++) begin
                if (clear_ok)       st_q[a] <= ST_UNK;
                else if (is_red[a]) st_q[a] <= ST_RED;
                else if (is_yel[a]) st_q[a] <= ST_YEL;
                else if (is_grn[a]) st_q[a] <= ST_GRN;

                if (is_yel[a]) begin
                    if (st_q[a] != ST_YEL)    ytmr_q[a] <= Y_ONE;
                    else if (ytmr_q[a] < Y_MIN) ytmr_q[a] <= ytmr_q[a] + Y_ONE;
                end
            end

            for (int i = 0; i < 4; i++) begin
                if (!bad[i])                run_q[i] <= '0;
                else if (run_q[i] < RUN_MAX) run_q[i] <= run_q[i] + R_ONE;
            end

            if (!fault) begin
                if (viol_code != 3'd0) begin
                    fault      <= 1'b1;
                    fault_code <= viol_code;
                    flash_red  <= 1'b1;
                    fdiv_q     <= '0;
                end
            end else if (clear_ok) begin
                fault      <= 1'b0;
                fault_code <= 3'd0;
                flash_red  <= 1'b0;
                fdiv_q     <= '0;
            end else begin
                // A clear refused by a live violation re-reports that violation.
                if (fault_clr) fault_code <= viol_code;
                if (fdiv_q == FDIV_END) begin
                    fdiv_q    <= '0;
                    flash_red <= ~flash_red;
                end else begin
                    fdiv_q <= fdiv_q + F_ONE;
                end
            end
        end
    end

`ifdef CONFLICT_MON_COUNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset)                                           cnt_q <= 8'd0;
        else if (!fault && viol_code != 3'd0 && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end

    assign fault_cnt = cnt_q;
`else
    assign fault_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Scoreboard bench for signal_conflict_monitor: directed scenarios then randomized traffic with injected faults.
module tb_signal_conflict_monitor;

    localparam int MIN_YELLOW     = 4;
    localparam int INVALID_CYCLES = 3;
    localparam int FLASH_DIV      = 8;
`ifdef CONFLICT_MON_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    localparam logic [11:0] ALLRED = 12'b100_100_100_000;
    localparam logic [11:0] CONF   = 12'b001_001_100_000;
    localparam logic [11:0] G1     = 12'b001_100_100_000;
    localparam logic [11:0] Y1     = 12'b010_100_100_000;
    localparam logic [11:0] BAD1   = 12'b000_100_100_000;
    localparam logic [11:0] G1G2W  = 12'b001_001_100_001;
    localparam logic [11:0] G1T    = 12'b001_100_100_100;
    localparam logic [11:0] RT     = 12'b100_100_100_100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] lamps = ALLRED;
    logic        fault_clr = 1'b0;
    logic        fault;
    logic [2:0]  fault_code;
    logic        flash_red;
    logic [7:0]  fault_cnt;

    signal_conflict_monitor #(
        .MIN_YELLOW(MIN_YELLOW), .INVALID_CYCLES(INVALID_CYCLES), .FLASH_DIV(FLASH_DIV)
    ) dut (
        .clock(clock), .reset(reset), .lamps(lamps), .fault_clr(fault_clr),
        .fault(fault), .fault_code(fault_code), .flash_red(flash_red), .fault_cnt(fault_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       f;
        logic [2:0] c;
        logic       fl;
        logic [7:0] n;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int nbad  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: colour last seen per approach, yellow run length, bad-run lengths, cycles since latch.
    logic [11:0] m_lq;
    byte         m_col[3];
    int          m_yrun[3];
    int          m_brun[4];
    bit          m_f;
    int          m_code;
    int          m_k;
    int          m_cnt;

    task automatic model_step(input logic [11:0] l, input logic clr, input logic rst);
        exp_t e;
        if (rst) begin
            for (int a = 0; a < 3; a++) begin m_col[a] = "U"; m_yrun[a] = 0; end
            for (int i = 0; i < 4; i++) m_brun[i] = 0;
            m_f = 0; m_code = 0; m_k = 0; m_cnt = 0;
        end else begin
            byte cur[3];
            int  run[4];
            int  nonred = 0;
            int  code = 0;
            bit  cleared = 0;
            bit [7:1] hit = '0;
            for (int a = 0; a < 3; a++) begin
                logic [2:0] s;
                s = m_lq[11-3*a -: 3];
                cur[a] = (s == 3'b100) ? "R" : (s == 3'b010) ? "Y" : (s == 3'b001) ? "G" : "X";
                if (cur[a] == "Y" || cur[a] == "G") nonred++;
            end
            hit[1] = nonred >= 2;
            hit[2] = m_lq[0] && nonred > 0;
            for (int a = 0; a < 3; a++) begin
                if (m_col[a] == "G" && cur[a] == "R") hit[3] = 1;
                if (m_col[a] == "Y" && cur[a] == "R" && m_yrun[a] < MIN_YELLOW) hit[4] = 1;
                if (m_col[a] == "Y" && cur[a] == "G") hit[5] = 1;
            end
            for (int i = 0; i < 3; i++) run[i] = (cur[i] == "X") ? m_brun[i] + 1 : 0;
            run[3] = (m_lq[1] && m_lq[0]) ? m_brun[3] + 1 : 0;
            for (int i = 0; i < 4; i++) if (run[i] >= INVALID_CYCLES) hit[6] = 1;
            hit[7] = m_lq[2] && cur[0] != "G";
            for (int c = 7; c >= 1; c--) if (hit[c]) code = c;

            if (!m_f) begin
                if (code != 0) begin
                    m_f = 1; m_code = code; m_k = 0;
                    if (m_cnt < 255) m_cnt++;
                end
            end else if (clr && code == 0) begin
                m_f = 0; m_code = 0; m_k = 0; cleared = 1;
            end else begin
                if (clr) m_code = code;
                m_k++;
            end

            for (int a = 0; a < 3; a++) begin
                if (cur[a] != "X") begin
                    if (cur[a] == "Y") m_yrun[a] = (m_col[a] == "Y") ? m_yrun[a] + 1 : 1;
                    m_col[a] = cur[a];
                end
                if (cleared) m_col[a] = "U";
            end
            for (int i = 0; i < 4; i++) m_brun[i] = run[i];
        end
        m_lq = rst ? 12'h000 : l;
        e.f  = m_f;
        e.c  = 3'(m_code);
        e.fl = m_f && (((m_k / FLASH_DIV) % 2) == 0);
        e.n  = (CNT_EN != 0) ? 8'(m_cnt) : 8'h00;
        sbq.push_back(e);
    endtask

    task automatic cyc(input logic [11:0] l, input logic c, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            lamps = l; fault_clr = c; reset = r;
            @(posedge clock);
            model_step(l, c, r);
            #1;
        end
    endtask

    task automatic clear_fault();
        cyc(ALLRED, 1'b0, 1'b0, 2);
        cyc(ALLRED, 1'b1, 1'b0, 1);
        cyc(ALLRED, 1'b0, 1'b0, 1);
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_fault",      fault,      e.f);
            chk("sb_fault_code", fault_code, e.c);
            chk("sb_flash_red",  flash_red,  e.fl);
            chk("sb_fault_cnt",  fault_cnt,  e.n);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cur_ap, ph, left;
        logic [11:0] v;

        cyc(ALLRED, 1'b0, 1'b1, 3);
        chk("rst_fault", fault, 0);
        chk("rst_code",  fault_code, 0);
        chk("rst_flash", flash_red, 0);
        chk("rst_cnt",   fault_cnt, 0);

        cyc(ALLRED, 1'b0, 1'b0, 2);
        for (int n = 0; n < 3; n++) begin
            cyc(CONF, 1'b0, 1'b0, 1);
            chk("conf_latency", fault, 0);
            cyc(ALLRED, 1'b0, 1'b0, 1);
            chk("conf_fault", fault, 1);
            chk("conf_code",  fault_code, 1);
            clear_fault();
            chk("conf_cleared", fault, 0);
        end
        chk("cnt_three", fault_cnt, 3 * CNT_EN);
        cyc(ALLRED, 1'b0, 1'b1, 2);
        chk("cnt_reset", fault_cnt, 0);

        cyc(ALLRED, 1'b0, 1'b0, 2);
        cyc(CONF, 1'b0, 1'b0, 1);
        cyc(ALLRED, 1'b0, 1'b0, 1);
        chk("flash_on", flash_red, 1);
        cyc(ALLRED, 1'b0, 1'b0, 7);
        chk("flash_hold", flash_red, 1);
        cyc(ALLRED, 1'b0, 1'b0, 1);
        chk("flash_toggle", flash_red, 0);
        cyc(ALLRED, 1'b0, 1'b0, 8);
        chk("flash_toggle2", flash_red, 1);
        clear_fault();
        chk("flash_cleared", flash_red, 0);

        cyc(G1, 1'b0, 1'b0, 3);
        cyc(ALLRED, 1'b0, 1'b0, 2);
        chk("skip_yellow", fault_code, 3);
        clear_fault();

        cyc(G1, 1'b0, 1'b0, 2);
        cyc(Y1, 1'b0, 1'b0, 3);
        cyc(ALLRED, 1'b0, 1'b0, 2);
        chk("short_yellow", fault_code, 4);
        clear_fault();
        cyc(G1, 1'b0, 1'b0, 2);
        cyc(Y1, 1'b0, 1'b0, 4);
        cyc(ALLRED, 1'b0, 1'b0, 3);
        chk("full_yellow", fault, 0);

        cyc(BAD1, 1'b0, 1'b0, 2);
        cyc(ALLRED, 1'b0, 1'b0, 3);
        chk("bad_two", fault, 0);
        cyc(BAD1, 1'b0, 1'b0, 3);
        cyc(ALLRED, 1'b0, 1'b0, 1);
        chk("bad_three", fault_code, 6);
        clear_fault();

        cyc(G1G2W, 1'b0, 1'b0, 2);
        chk("prio_code", fault_code, 1);
        cyc(G1G2W, 1'b1, 1'b0, 1);
        chk("clr_held_fault", fault, 1);
        chk("clr_held_code",  fault_code, 1);
        clear_fault();
        chk("clr_ok_fault", fault, 0);
        chk("clr_ok_flash", flash_red, 0);

        cyc(G1T, 1'b0, 1'b0, 2);
        cyc(Y1, 1'b0, 1'b0, 4);
        cyc(ALLRED, 1'b0, 1'b0, 3);
        chk("turn_ok", fault, 0);
        cyc(RT, 1'b0, 1'b0, 1);
        cyc(ALLRED, 1'b0, 1'b0, 1);
        chk("turn_bad", fault_code, 7);
        clear_fault();

        cur_ap = 0; ph = 2; left = 2;
        for (int t = 0; t < 3000; t++) begin
            v = '0;
            for (int a = 0; a < 3; a++)
                v[11-3*a -: 3] = (a == cur_ap && ph == 0) ? 3'b001 :
                                 (a == cur_ap && ph == 1) ? 3'b010 : 3'b100;
            if (cur_ap == 0 && ph == 0 && $urandom_range(0, 3) == 0) v[2] = 1'b1;
            if (ph == 2 && $urandom_range(0, 2) == 0) v[0] = 1'b1;
            else if ($urandom_range(0, 5) == 0) v[1] = 1'b1;
            if ($urandom_range(0, 99) < 3) v = 12'($urandom);
            cyc(v, $urandom_range(0, 99) < 6, $urandom_range(0, 999) < 3, 1);
            left--;
            if (left <= 0) begin
                case (ph)
                    0:       begin ph = 1; left = $urandom_range(3, 6); end
                    1:       begin ph = 2; left = $urandom_range(1, 2); end
                    default: begin ph = 0; cur_ap = (cur_ap + 1) % 3; left = $urandom_range(2, 5); end
                endcase
            end
        end

        cyc(ALLRED, 1'b0, 1'b0, 1);
        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clock);
        if (sbq.size() > 0) chk("drain", sbq.size(), 0);
        #1;
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule
